// File: rtl/stall_ctrl.sv
// Pipeline stall/flush controller: merges load-use, multi-cycle MDU and MEM-wait
// requests into a prefix-shaped stall vector and sequences MDU completion and flushes.
module stall_ctrl #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_use_i,
  input  logic             mdu_start_i,
  input  logic [CNT_W-1:0] mdu_cycles_i,
  input  logic             mem_wait_i,
  input  logic             flush_i,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             flush_o,
  output logic             mdu_done_o,
  output logic             busy_o
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             flush_pend;

  logic start_long;
  logic start_short;
  logic cnt_zero;
  logic mdu_stall;
  logic ld_stall;

  // Zero-latency request merge; a flush overrides the EX/ID requests but never MEM wait.
  always_comb begin
    flush_o     = (flush_i | flush_pend) & ~mem_wait_i;
    cnt_zero    = (cnt == '0);
    start_long  = (state == IDLE) & mdu_start_i & (mdu_cycles_i > CNT_W'(1)) & ~flush_o;
    start_short = (state == IDLE) & mdu_start_i & (mdu_cycles_i <= CNT_W'(1)) & ~flush_o;
    mdu_stall   = start_long | ((state == BUSY) & ~cnt_zero & ~flush_o);
    ld_stall    = ld_use_i & ~flush_o;
    mdu_done_o  = ~flush_o & ~mem_wait_i & (start_short | ((state == BUSY) & cnt_zero));
    stall_mem   = mem_wait_i;
    stall_ex    = mem_wait_i | mdu_stall;
    stall_id    = mem_wait_i | mdu_stall | ld_stall;
    stall_if    = mem_wait_i | mdu_stall | ld_stall;
    busy_o      = (state == BUSY);
  end

  // The start cycle counts as the first latency cycle, so BUSY is loaded with N-2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      flush_pend <= 1'b0;
    end else if (flush_o) begin
      state      <= IDLE;
      cnt        <= '0;
      flush_pend <= 1'b0;
    end else begin
      if (flush_i & mem_wait_i) begin
        flush_pend <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start_long) begin
            state <= BUSY;
            cnt   <= mdu_cycles_i - CNT_W'(2);
          end
        end
        BUSY: begin
          if (!cnt_zero) begin
            cnt <= cnt - CNT_W'(1);
          end else if (!mem_wait_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stall_ctrl.sv
// Self-checking bench for stall_ctrl: directed latency/flush/reset scenarios plus
// randomized traffic compared against an op-age based behavioural model.
module tb_stall_ctrl;

  localparam int unsigned CNT_W = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             ld_use_i;
  logic             mdu_start_i;
  logic [CNT_W-1:0] mdu_cycles_i;
  logic             mem_wait_i;
  logic             flush_i;
  logic             stall_if;
  logic             stall_id;
  logic             stall_ex;
  logic             stall_mem;
  logic             flush_o;
  logic             mdu_done_o;
  logic             busy_o;

  stall_ctrl #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .ld_use_i     (ld_use_i),
    .mdu_start_i  (mdu_start_i),
    .mdu_cycles_i (mdu_cycles_i),
    .mem_wait_i   (mem_wait_i),
    .flush_i      (flush_i),
    .stall_if     (stall_if),
    .stall_id     (stall_id),
    .stall_ex     (stall_ex),
    .stall_mem    (stall_mem),
    .flush_o      (flush_o),
    .mdu_done_o   (mdu_done_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: an op is tracked by its age in cycles since the start cycle (age 0).
  bit m_active;
  int m_n;
  int m_age;
  bit m_pend;

  // Per-scenario observations
  int cyc_idx, n_stall_ex, n_done, done_at, n_flush, flush_at, n_stall4;

  function automatic logic [3:0] dut_vec();
    return {stall_mem, stall_ex, stall_id, stall_if};
  endfunction

  task automatic model_reset();
    m_active = 0;
    m_n      = 0;
    m_age    = 0;
    m_pend   = 0;
  endtask

  task automatic scen_reset();
    cyc_idx = 0; n_stall_ex = 0; n_done = 0; done_at = 0;
    n_flush = 0; flush_at = 0; n_stall4 = 0;
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model.
  task automatic cyc(input logic ld, input logic st, input int n, input logic mw, input logic fl);
    bit e_flush, e_mstall, e_done;
    int nn;
    logic [3:0] e_vec;
    @(negedge clk);
    ld_use_i     = ld;
    mdu_start_i  = st;
    mdu_cycles_i = CNT_W'(n);
    mem_wait_i   = mw;
    flush_i      = fl;
    #1;
    nn      = int'(mdu_cycles_i);
    e_flush = (fl || m_pend) && !mw;
    e_mstall = 0;
    e_done   = 0;
    if (!e_flush) begin
      if (m_active) begin
        e_mstall = (m_age < m_n - 1);
        e_done   = (m_age >= m_n - 1) && !mw;
      end else if (st) begin
        e_mstall = (nn >= 2);
        e_done   = (nn < 2) && !mw;
      end
    end
    if (mw)                     e_vec = 4'b1111;
    else if (e_mstall)          e_vec = 4'b0111;
    else if (ld && !e_flush)    e_vec = 4'b0011;
    else                        e_vec = 4'b0000;
    check("stall_vec", 32'(dut_vec()), 32'(e_vec));
    check("flush_o", 32'(flush_o), 32'(e_flush));
    check("mdu_done", 32'(mdu_done_o), 32'(e_done));
    check("busy_o", 32'(busy_o), 32'(m_active));

    cyc_idx++;
    if (stall_ex) n_stall_ex++;
    if (dut_vec() == 4'b1111) n_stall4++;
    if (mdu_done_o) begin n_done++; done_at = cyc_idx; end
    if (flush_o) begin n_flush++; flush_at = cyc_idx; end

    if (e_flush) begin
      m_active = 0;
      m_pend   = 0;
    end else begin
      if (fl && mw) m_pend = 1;
      if (m_active) begin
        if (e_done) m_active = 0;
        else        m_age++;
      end else if (st && nn >= 2) begin
        m_active = 1;
        m_age    = 1;
        m_n      = nn;
      end
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    ld_use_i = 0; mdu_start_i = 0; mdu_cycles_i = '0; mem_wait_i = 0; flush_i = 0;
    model_reset();
    #3;
    check("rst_vec", 32'(dut_vec()), 32'h0);
    check("rst_busy", 32'(busy_o), 32'h0);
    check("rst_done", 32'(mdu_done_o), 32'h0);
    check("rst_flush", 32'(flush_o), 32'h0);
    ld_use_i = 1; #1;
    check("rst_ld_vec", 32'(dut_vec()), 32'h3);
    mem_wait_i = 1; #1;
    check("rst_mw_vec", 32'(dut_vec()), 32'hf);
    ld_use_i = 0; mem_wait_i = 0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    idle(2);

    // Load-use single cycle
    scen_reset();
    cyc(1, 0, 0, 0, 0);
    check("lu_vec", 32'(dut_vec()), 32'h3);
    cyc(0, 0, 0, 0, 0);
    check("lu_after", 32'(dut_vec()), 32'h0);
    check("lu_busy", 32'(busy_o), 32'h0);

    // N=5 latency
    scen_reset();
    cyc(0, 1, 5, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0);
    check("n5_stall_cnt", 32'(n_stall_ex), 32'd4);
    check("n5_done_at", 32'(done_at), 32'd5);
    check("n5_done_cnt", 32'(n_done), 32'd1);

    // N=1 latency
    scen_reset();
    cyc(0, 1, 1, 0, 0);
    check("n1_done", 32'(mdu_done_o), 32'h1);
    check("n1_vec", 32'(dut_vec()), 32'h0);
    idle(2);

    // N=3 with mem wait in cycles 2-6
    scen_reset();
    cyc(0, 1, 3, 0, 0);
    for (int c = 2; c <= 9; c++) cyc(0, 0, 0, (c >= 2 && c <= 6), 0);
    check("mw_stall4_cnt", 32'(n_stall4), 32'd5);
    check("mw_done_at", 32'(done_at), 32'd7);
    check("mw_done_cnt", 32'(n_done), 32'd1);

    // Deferred flush, repeated flush_i coalesces
    scen_reset();
    for (int c = 1; c <= 7; c++) cyc(0, 0, 0, (c <= 4), (c == 2 || c == 3));
    check("df_flush_at", 32'(flush_at), 32'd5);
    check("df_flush_cnt", 32'(n_flush), 32'd1);

    // Flush aborts a long op
    scen_reset();
    cyc(0, 1, 10, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    check("fa_stall_ex", 32'(stall_ex), 32'h0);
    cyc(0, 0, 0, 0, 0);
    check("fa_busy", 32'(busy_o), 32'h0);
    idle(12);
    check("fa_done_cnt", 32'(n_done), 32'd0);

    // Async reset mid-op
    scen_reset();
    cyc(0, 1, 10, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    mdu_start_i = 0;
    #2 rst = 1'b1;
    #1;
    check("ar_busy", 32'(busy_o), 32'h0);
    check("ar_stall_ex", 32'(stall_ex), 32'h0);
    rst = 1'b0;
    model_reset();
    scen_reset();
    idle(12);
    check("ar_stall_after", 32'(n_stall_ex), 32'd0);
    check("ar_done_after", 32'(n_done), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int n;
      n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 12));
      cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0), n,
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 11) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
